// File: rtl/modbus_rtu_pkg.sv
// rtl/modbus_rtu_pkg.sv - shared states and constants for the Modbus RTU receive path
package modbus_rtu_pkg;

  // Receive-frame controller states
  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_READY   = 3'd1,
    ST_RECV    = 3'd2,
    ST_IGNORE  = 3'd3,
    ST_DROP    = 3'd4,
    ST_HOLD    = 3'd5,
    ST_FLUSH   = 3'd6
  } fsm_state_t;

  // Inter-character gap thresholds, in bit-times
  localparam int T15_MULT = 15;
  localparam int T35_MULT = 35;

  localparam logic [7:0] BROADCAST_ADDR = 8'h00;

  // Smallest legal frame: address, function code and two CRC bytes
  localparam int MIN_LEN_DEFAULT = 4;

endpackage

// File: rtl/modbus_gap_timer.sv
// rtl/modbus_gap_timer.sv - line-silence counter flagging 1.5T and 3.5T gaps
module modbus_gap_timer
  import modbus_rtu_pkg::*;
#(
  parameter int BPS = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_done,
  input  logic rx_state,
  output logic gap15,
  output logic gap35
);

  localparam int T15_CYC = T15_MULT * BPS;
  localparam int T35_CYC = T35_MULT * BPS;
  localparam int CW      = $clog2(T35_CYC + 1);

  logic [CW-1:0] cnt;

  // Count quiet cycles since the last line activity, saturating at 3.5T
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rx_done || rx_state) begin
      cnt <= '0;
    end else if (cnt != CW'(T35_CYC)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign gap15 = (cnt >= CW'(T15_CYC));
  assign gap35 = (cnt == CW'(T35_CYC));

endmodule

// File: rtl/modbus_rx_frame_ctrl.sv
// rtl/modbus_rx_frame_ctrl.sv - Modbus RTU receive framing, address filter and frame buffer
module modbus_rx_frame_ctrl
  import modbus_rtu_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int MAX_LEN   = 256,
  parameter int MIN_LEN   = MIN_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_state,
  input  logic [7:0] slave_addr,
  output logic       frame_valid,
  output logic [8:0] frame_len,
  output logic       frame_bcast,
  input  logic       frame_ack,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       err_gap,
  output logic       err_len,
  output logic       err_overrun
);

  localparam int BPS = CLK_FREQ / BAUD_RATE;

  fsm_state_t state, state_next;
  logic [8:0] len, len_next;
  logic       gap15, gap35;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic       gap_err_c, len_err_c, ovr_err_c;
  logic       hold_enter, recv_enter;
  logic [7:0] mem [MAX_LEN];

  modbus_gap_timer #(
    .BPS(BPS)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .rx_done  (rx_done),
    .rx_state (rx_state),
    .gap15    (gap15),
    .gap35    (gap35)
  );

  // Frame sequencing: next state, buffer write strobe and error causes
  always_comb begin
    state_next = state;
    len_next   = len;
    wr_en      = 1'b0;
    wr_addr    = '0;
    gap_err_c  = 1'b0;
    len_err_c  = 1'b0;
    ovr_err_c  = 1'b0;
    hold_enter = 1'b0;
    recv_enter = 1'b0;
    case (state)
      ST_STARTUP: begin
        if (!rx_done && gap35) state_next = ST_READY;
      end
      ST_READY: begin
        if (rx_done) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          len_next = 9'd1;
          if (rx_data == slave_addr || rx_data == BROADCAST_ADDR) begin
            state_next = ST_RECV;
            recv_enter = 1'b1;
          end else begin
            state_next = ST_IGNORE;
          end
        end
      end
      ST_RECV: begin
        if (rx_done) begin
          if (gap15) begin
            gap_err_c  = 1'b1;
            state_next = ST_DROP;
          end else if (len == 9'(MAX_LEN)) begin
            len_err_c  = 1'b1;
            state_next = ST_DROP;
          end else begin
            wr_en    = 1'b1;
            wr_addr  = len[7:0];
            len_next = len + 9'd1;
          end
        end else if (gap35) begin
          if (len >= 9'(MIN_LEN)) begin
            state_next = ST_HOLD;
            hold_enter = 1'b1;
          end else begin
            len_err_c  = 1'b1;
            state_next = ST_READY;
          end
        end
      end
      ST_IGNORE, ST_DROP, ST_FLUSH: begin
        if (!rx_done && gap35) state_next = ST_READY;
      end
      ST_HOLD: begin
        if (rx_done) ovr_err_c = 1'b1;
        if (frame_ack) state_next = ST_FLUSH;
      end
      default: state_next = ST_STARTUP;
    endcase
  end

  // State, length and held-frame descriptor registers; error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_STARTUP;
      len         <= '0;
      frame_len   <= '0;
      frame_bcast <= 1'b0;
      err_gap     <= 1'b0;
      err_len     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_next;
      len         <= len_next;
      err_gap     <= gap_err_c;
      err_len     <= len_err_c;
      err_overrun <= ovr_err_c;
      if (hold_enter) frame_len <= len;
      if (recv_enter) frame_bcast <= (rx_data == BROADCAST_ADDR);
    end
  end

  // Frame buffer write port, owned by the sequencer
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= rx_data;
  end

  // Free-running registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= 8'h00;
    else     rd_data <= mem[rd_addr];
  end

  assign frame_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_modbus_rx_frame_ctrl.sv
// tb/tb_modbus_rx_frame_ctrl.sv - self-checking bench for modbus_rx_frame_ctrl
module tb_modbus_rx_frame_ctrl;

  localparam int CLK_FREQ  = 1000000;
  localparam int BAUD_RATE = 100000;
  localparam int MAX_LEN   = 256;
  localparam int MIN_LEN   = 4;
  localparam int T15       = 150;
  localparam int T35       = 350;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_state = 1'b0;
  logic [7:0] slave_addr = 8'h01;
  logic       frame_ack = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic       frame_valid, frame_bcast, err_gap, err_len, err_overrun;
  logic [8:0] frame_len;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] fa [8] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};

  always #5 clk = ~clk;

  modbus_rx_frame_ctrl #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)
  ) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data), .rx_state(rx_state),
    .slave_addr(slave_addr), .frame_valid(frame_valid), .frame_len(frame_len),
    .frame_bcast(frame_bcast), .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rd_data),
    .err_gap(err_gap), .err_len(err_len), .err_overrun(err_overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_SIL = 0, M_IDLE = 1, M_COL = 2, M_SKIP = 3, M_DIS = 4, M_HELD = 5, M_DRAIN = 6;
  int          m_mode, m_quiet;
  byte unsigned m_cur[$], m_held[$];
  bit          m_cur_bc, m_held_bc;
  bit          x_gap, x_len, x_ovr, x_rd_ok;
  int          x_rd;

  task automatic model_reset();
    m_mode = M_SIL; m_quiet = 0;
    m_cur.delete(); m_held.delete();
    m_cur_bc = 0; m_held_bc = 0;
    x_gap = 0; x_len = 0; x_ovr = 0; x_rd_ok = 0; x_rd = 0;
  endtask

  // Advance the model across one clock edge using the inputs the DUT will sample
  task automatic model_step();
    bit g15, g35;
    g15 = (m_quiet >= T15);
    g35 = (m_quiet == T35);
    x_gap = 0; x_len = 0; x_ovr = 0;
    case (m_mode)
      M_SIL: if (!rx_done && g35) m_mode = M_IDLE;
      M_IDLE: if (rx_done) begin
        m_cur.delete();
        m_cur.push_back(rx_data);
        if (rx_data == slave_addr || rx_data == 8'h00) begin
          m_mode = M_COL; m_cur_bc = (rx_data == 8'h00);
        end else m_mode = M_SKIP;
      end
      M_COL: if (rx_done) begin
        if (g15) begin x_gap = 1; m_mode = M_DIS; end
        else if (m_cur.size() == MAX_LEN) begin x_len = 1; m_mode = M_DIS; end
        else m_cur.push_back(rx_data);
      end else if (g35) begin
        if (m_cur.size() >= MIN_LEN) begin
          m_held = m_cur; m_held_bc = m_cur_bc; m_mode = M_HELD;
        end else begin x_len = 1; m_mode = M_IDLE; end
      end
      M_SKIP, M_DIS, M_DRAIN: if (!rx_done && g35) m_mode = M_IDLE;
      M_HELD: begin
        if (rx_done) x_ovr = 1;
        if (frame_ack) m_mode = M_DRAIN;
      end
      default: m_mode = M_SIL;
    endcase
    if (rx_done || rx_state) m_quiet = 0;
    else if (m_quiet < T35) m_quiet++;
    x_rd_ok = (m_mode == M_HELD) && (int'(rd_addr) < m_held.size());
    if (x_rd_ok) x_rd = m_held[rd_addr];
  endtask

  // Compare DUT against the model every cycle, mid-cycle
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) model_reset();
      chk("frame_valid", frame_valid, m_mode == M_HELD);
      chk("err_gap", err_gap, x_gap);
      chk("err_len", err_len, x_len);
      chk("err_overrun", err_overrun, x_ovr);
      if (rst) begin
        chk("rst_frame_len", frame_len, 0);
        chk("rst_frame_bcast", frame_bcast, 0);
        chk("rst_rd_data", rd_data, 0);
      end else if (m_mode == M_HELD) begin
        chk("frame_len", frame_len, m_held.size());
        chk("frame_bcast", frame_bcast, m_held_bc);
        if (x_rd_ok) chk("rd_data", rd_data, x_rd);
      end
      if (!rst) model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) idle(99);
      send_byte(i == 0 ? a0 : fa[i]);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!frame_valid && n < 400) begin @(posedge clk); #1; n++; end
  endtask

  task automatic read_check();
    for (int i = 0; i < 8; i++) begin
      rd_addr = 8'(i);
      @(posedge clk); #1;
      chk("rd_byte", rd_data, fa[i]);
    end
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    chk("valid_after_ack", frame_valid, 0);
  endtask

  initial begin
    int n;
    idle(5);
    chk("reset_valid", frame_valid, 0);
    chk("reset_len", frame_len, 0);
    rst = 1'b0;
    idle(360);

    // Addressed frame: latency, length, contents
    send_frame(8'h01);
    wait_valid(n);
    chk("valid_latency", n, 351);
    chk("len_8", frame_len, 9'd8);
    chk("bcast_0", frame_bcast, 0);
    read_check();
    ack();
    idle(10);

    // Broadcast frame
    send_frame(8'h00);
    wait_valid(n);
    chk("bcast_latency", n, 351);
    chk("bcast_1", frame_bcast, 1);
    ack();
    idle(10);

    // Foreign address: silently ignored
    send_frame(8'h05);
    idle(351);
    chk("foreign_no_valid", frame_valid, 0);
    idle(10);

    // 1.5T violation on the 4th byte
    send_byte(8'h01); idle(99); send_byte(8'h03); idle(99); send_byte(8'h00);
    idle(199);
    send_byte(8'h00);
    chk("gap_pulse", err_gap, 1);
    idle(1);
    chk("gap_pulse_end", err_gap, 0);
    for (int i = 5; i < 8; i++) begin idle(98); send_byte(fa[i]); end
    idle(360);

    // Short frame
    send_byte(8'h01); idle(99); send_byte(8'h03); idle(99); send_byte(8'h00);
    idle(350);
    chk("short_len_early", err_len, 0);
    idle(1);
    chk("short_len", err_len, 1);
    chk("short_no_valid", frame_valid, 0);
    idle(10);

    // Over-long stream
    for (int i = 0; i < 257; i++) begin
      if (i > 0) idle(19);
      send_byte(i == 0 ? 8'h01 : 8'(i));
      if (i == 255) chk("long_256_ok", err_len, 0);
      if (i == 256) chk("long_257_err", err_len, 1);
    end
    idle(360);

    // Overrun while held, then flush discipline
    send_frame(8'h01);
    wait_valid(n);
    chk("ovr_latency", n, 351);
    send_byte(8'hFF);
    chk("overrun_pulse", err_overrun, 1);
    read_check();
    chk("ovr_len_kept", frame_len, 9'd8);
    ack();
    rx_state = 1'b1; idle(50); rx_state = 1'b0;
    idle(100);
    send_frame(8'h01);
    idle(351);
    chk("flush_no_valid", frame_valid, 0);
    idle(10);
    send_frame(8'h01);
    wait_valid(n);
    chk("after_flush_latency", n, 351);
    read_check();
    ack();
    idle(10);

    // Reset in the middle of byte 5
    for (int i = 0; i < 4; i++) begin
      if (i > 0) idle(99);
      send_byte(fa[i]);
    end
    idle(50);
    rx_state = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", frame_valid, 0);
    chk("rst_mid_len", frame_len, 0);
    chk("rst_mid_rd", rd_data, 0);
    chk("rst_mid_errs", {err_gap, err_len, err_overrun, frame_bcast}, 0);
    rx_state = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(20);
    send_frame(8'h01);
    idle(351);
    chk("startup_no_valid", frame_valid, 0);
    idle(10);
    send_frame(8'h01);
    wait_valid(n);
    chk("post_reset_latency", n, 351);
    ack();
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
